// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one simpleuart transmitter between NREQ byte-stream requesters.
//   Requesters are picked round-robin; an owner keeps the UART for a whole
//   message (terminated by req_last) so messages never interleave. Only one
//   byte is ever in flight: the next write waits for the UART frame ack.
//   If a locked owner stops presenting bytes for LOCK_TIMEOUT cycles, the
//   lock is forcibly released. LOCK_TIMEOUT == 0 disables locking.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   req_valid[i]       requester i presents a byte (held until req_ready[i])
//   req_data[8i+7:8i]  byte of requester i
//   req_last[i]        byte is the final one of the message
//   req_ready[i]       one-cycle pulse: byte of requester i consumed
//   grant              one-hot current owner, 0 when idle
//   busy               controller not idle
//   lock_timeout       one-cycle pulse on forced lock release
//   uart_dat_we/_di    write strobe and data to simpleuart
//   uart_dat_ack       end-of-frame pulse from simpleuart
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              lock_timeout,
  output logic              uart_dat_we,
  output logic [31:0]       uart_dat_di,
  input  logic              uart_dat_ack
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Last timer value before a forced release; unused when locking is off.
  localparam logic [15:0]     HOLD_LAST = (LOCK_TIMEOUT > 0) ? 16'(LOCK_TIMEOUT - 1) : 16'd0;
  localparam logic            NO_LOCK   = (LOCK_TIMEOUT == 0);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [15:0]     timer_q, timer_d;
  logic            last_q, last_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   owner_next;
  logic [NREQ-1:0] owner_oh;
  logic            owner_valid;

  // Round-robin search starting at rr_q. Scanning from the far end down
  // lets the candidate closest to rr_q overwrite the others.
  always_comb begin : arb
    logic [IW-1:0] idx;
    idx        = '0;
    pick_found = 1'b0;
    pick_idx   = rr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_next  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign owner_oh    = ONE_HOT0 << owner_q;

  always_comb begin : fsm
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    timer_d      = timer_q;
    last_d       = last_q;
    lock_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        last_d  = req_last[owner_q] | NO_LOCK;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Only the ack of the frame we issued matters; acks seen in any
        // other state (e.g. a frame started before a reset) are dropped.
        if (uart_dat_ack) begin
          if (last_q) begin
            rr_d    = owner_next;
            state_d = ST_IDLE;
          end else if (owner_valid) begin
            state_d = ST_SEND;
          end else begin
            timer_d = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (owner_valid) begin
          state_d = ST_SEND;
        end else if (timer_q == HOLD_LAST) begin
          lock_timeout = 1'b1;
          rr_d         = owner_next;
          state_d      = ST_IDLE;
        end else if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      last_q  <= last_d;
    end
  end

  // Write strobe, data and consume pulse are all decoded from SEND so the
  // byte handed to the UART is exactly the one acknowledged to the owner.
  assign busy        = (state_q != ST_IDLE);
  assign grant       = busy ? owner_oh : '0;
  assign uart_dat_we = (state_q == ST_SEND);
  assign req_ready   = uart_dat_we ? owner_oh : '0;
  assign uart_dat_di = uart_dat_we ? {24'h0, req_data[8*owner_q +: 8]} : 32'h0;

endmodule
